bin_erode_box: RTL and testbench

Downstream of `bin_buffers`: takes its binarised `o_pack` stream and the `ROW`-bit vertical `window` column, and forms a `ROW`×`ROW` neighbourhood with a horizontal shift register. It emits an eroded binary video stream in which a pixel is white only if the whole neighbourhood is white. It also accumulates the per-frame bounding box of eroded foreground, which feeds the aiming logic.

---
 rtl/bin_pkg.sv | 28 ++
 rtl/bin_erode_box_bbox_accum.sv | 65 ++++++
 rtl/bin_erode_box.sv | 138 +++++++++++++
 tb/tb_bin_erode_box.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bin_pkg.sv
// Shared types and width helpers for the binary-image processing chain.
package bin_pkg;

  // Box fields are wide enough for any 12-bit frame dimension; users keep the low bits.
  localparam int BOX_W = 12;

  typedef struct packed {
    logic [BOX_W-1:0] x_min;
    logic [BOX_W-1:0] x_max;
    logic [BOX_W-1:0] y_min;
    logic [BOX_W-1:0] y_max;
    logic             valid;
  } box_t;

  function automatic int x_w(input int h_act);
    return $clog2(h_act);
  endfunction

  function automatic int y_w(input int v_act);
    return $clog2(v_act);
  endfunction

  // Stream word: {pclk, hsync, vsync, de, r[7:0], g[7:0], b[7:0], x, y}.
  function automatic int pack_size(input int h_act, input int v_act);
    return 3 * 8 + 4 + x_w(h_act) + y_w(v_act);
  endfunction

endpackage

// File: rtl/bin_erode_box_bbox_accum.sv
// Per-frame bounding box of foreground pixels, published on frame end.
module bbox_accum
  import bin_pkg::*;
#(
  parameter int  H_ACT = 1280,
  parameter int  V_ACT = 720,
  localparam int X_W   = x_w(H_ACT),
  localparam int Y_W   = y_w(V_ACT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pix_en,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic           frame_end,
  output box_t           box,
  output logic           box_update
);

  localparam logic [X_W-1:0] X_MIN_INIT = X_W'(H_ACT - 1);
  localparam logic [Y_W-1:0] Y_MIN_INIT = Y_W'(V_ACT - 1);

  logic [X_W-1:0] acc_x_min_reg, acc_x_max_reg;
  logic [Y_W-1:0] acc_y_min_reg, acc_y_max_reg;
  logic           acc_any_reg;
  box_t           box_reg;
  logic           box_update_reg;

  // Accumulate extents; frame end publishes and restarts (a coincident pixel is dropped).
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_x_min_reg  <= X_MIN_INIT;
      acc_x_max_reg  <= '0;
      acc_y_min_reg  <= Y_MIN_INIT;
      acc_y_max_reg  <= '0;
      acc_any_reg    <= 1'b0;
      box_reg        <= '0;
      box_update_reg <= 1'b0;
    end else begin
      box_update_reg <= frame_end;
      if (frame_end) begin
        box_reg.x_min <= BOX_W'(acc_x_min_reg);
        box_reg.x_max <= BOX_W'(acc_x_max_reg);
        box_reg.y_min <= BOX_W'(acc_y_min_reg);
        box_reg.y_max <= BOX_W'(acc_y_max_reg);
        box_reg.valid <= acc_any_reg;
        acc_x_min_reg <= X_MIN_INIT;
        acc_x_max_reg <= '0;
        acc_y_min_reg <= Y_MIN_INIT;
        acc_y_max_reg <= '0;
        acc_any_reg   <= 1'b0;
      end else if (pix_en) begin
        if (x < acc_x_min_reg) acc_x_min_reg <= x;
        if (x > acc_x_max_reg) acc_x_max_reg <= x;
        if (y < acc_y_min_reg) acc_y_min_reg <= y;
        if (y > acc_y_max_reg) acc_y_max_reg <= y;
        acc_any_reg <= 1'b1;
      end
    end
  end

  assign box        = box_reg;
  assign box_update = box_update_reg;

endmodule

// File: rtl/bin_erode_box.sv
// ROW x ROW binary erosion of the windowed stream plus per-frame bounding box.
module bin_erode_box
  import bin_pkg::*;
#(
  parameter int  H_ACT     = 1280,
  parameter int  V_ACT     = 720,
  parameter int  ROW       = 4,
  localparam int X_W       = x_w(H_ACT),
  localparam int Y_W       = y_w(V_ACT),
  localparam int PACK_SIZE = pack_size(H_ACT, V_ACT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PACK_SIZE-1:0] i_pack,
  input  logic [ROW-1:0]       window,
  output logic [PACK_SIZE-1:0] o_pack,
  output logic [X_W-1:0]       box_x_min,
  output logic [X_W-1:0]       box_x_max,
  output logic [Y_W-1:0]       box_y_min,
  output logic [Y_W-1:0]       box_y_max,
  output logic                 box_valid,
  output logic                 box_update
);

  localparam int FILL_W  = $clog2(ROW);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(ROW - 1);
  localparam logic [FILL_W-1:0] FILL_PRE  = FILL_W'(ROW - 2);

  localparam int X_LSB   = Y_W;
  localparam int RGB_LSB = X_W + Y_W;
  localparam int DE_BIT  = RGB_LSB + 24;
  localparam int VS_BIT  = DE_BIT + 1;
  localparam int HS_BIT  = VS_BIT + 1;
  localparam int CK_BIT  = HS_BIT + 1;

  logic           in_ck, in_hs, in_vs, in_de;
  logic [X_W-1:0] in_x;
  logic [Y_W-1:0] in_y;

  assign in_ck = i_pack[CK_BIT];
  assign in_hs = i_pack[HS_BIT];
  assign in_vs = i_pack[VS_BIT];
  assign in_de = i_pack[DE_BIT];
  assign in_x  = i_pack[X_LSB +: X_W];
  assign in_y  = i_pack[0 +: Y_W];

  // col_reg[ROW-1] is the newest column; col_reg[0] is the one about to fall out.
  logic [ROW-1:0][ROW-1:0] col_reg;
  logic [FILL_W-1:0]       fill_reg;
  logic [ROW-2:0]          hist_and;
  logic                    eroded_next;

  genvar gi;
  generate
    for (gi = 0; gi < ROW - 1; gi++) begin : g_hist
      assign hist_and[gi] = &col_reg[gi + 1];
    end
  endgenerate

  // Neighbourhood = stored columns 1..ROW-1 plus the incoming column.
  assign eroded_next = in_de && ((fill_reg == FILL_FULL) || (fill_reg == FILL_PRE))
                       && (&window) && (&hist_and);

  // Horizontal shift register and fill count; both restart on every blanking gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg  <= '0;
      fill_reg <= '0;
    end else if (in_de) begin
      col_reg <= {window, col_reg[ROW-1:1]};
      if (fill_reg != FILL_FULL) fill_reg <= fill_reg + 1'b1;
    end else begin
      col_reg  <= '0;
      fill_reg <= '0;
    end
  end

  logic           eroded_reg, ck_d, hs_d, vs_d, de_d, vs_d2;
  logic [X_W-1:0] x_d;
  logic [Y_W-1:0] y_d;

  // One-cycle alignment of sync/coordinates with the registered erosion result.
  always_ff @(posedge clk) begin
    if (rst) begin
      eroded_reg <= 1'b0;
      ck_d       <= 1'b0;
      hs_d       <= 1'b0;
      vs_d       <= 1'b0;
      de_d       <= 1'b0;
      x_d        <= '0;
      y_d        <= '0;
      vs_d2      <= 1'b0;
    end else begin
      eroded_reg <= eroded_next;
      ck_d       <= in_ck;
      hs_d       <= in_hs;
      vs_d       <= in_vs;
      de_d       <= in_de;
      x_d        <= in_x;
      y_d        <= in_y;
      vs_d2      <= vs_d;
    end
  end

  assign o_pack = {ck_d, hs_d, vs_d, de_d, {24{eroded_reg}}, x_d, y_d};

  // Frame end is the vsync rise on the output side, so it orders cleanly with pix_en.
  logic frame_end, pix_en;
  assign frame_end = vs_d & ~vs_d2;
  assign pix_en    = eroded_reg & de_d;

  box_t box;

  bbox_accum #(
    .H_ACT(H_ACT),
    .V_ACT(V_ACT)
  ) u_bbox (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (pix_en),
    .x         (x_d),
    .y         (y_d),
    .frame_end (frame_end),
    .box       (box),
    .box_update(box_update)
  );

  assign box_x_min = box.x_min[X_W-1:0];
  assign box_x_max = box.x_max[X_W-1:0];
  assign box_y_min = box.y_min[Y_W-1:0];
  assign box_y_max = box.y_max[Y_W-1:0];
  assign box_valid = box.valid;

  // Incoming colour, the oldest column and the wide box field tops are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{box, i_pack[RGB_LSB +: 24], col_reg[0]};

endmodule

// File: tb/tb_bin_erode_box.sv
// Random and directed frames against a run-length erosion model and a bounding-box model.
module tb_bin_erode_box;
  import bin_pkg::*;

  localparam int H_ACT = 16;
  localparam int V_ACT = 8;
  localparam int ROW   = 4;
  localparam int X_W   = x_w(H_ACT);
  localparam int Y_W   = y_w(V_ACT);
  localparam int PS    = pack_size(H_ACT, V_ACT);

  logic           clk = 1'b0;
  logic           rst;
  logic [PS-1:0]  i_pack, o_pack;
  logic [ROW-1:0] window;
  logic [X_W-1:0] box_x_min, box_x_max;
  logic [Y_W-1:0] box_y_min, box_y_max;
  logic           box_valid, box_update;

  logic           d_rst = 1'b1, d_ck = 1'b0, d_hs = 1'b0, d_vs = 1'b0, d_de = 1'b0;
  logic [23:0]    d_rgb = '0;
  logic [X_W-1:0] d_x = '0;
  logic [Y_W-1:0] d_y = '0;
  logic [ROW-1:0] d_win = '0;

  assign rst    = d_rst;
  assign window = d_win;
  assign i_pack = {d_ck, d_hs, d_vs, d_de, d_rgb, d_x, d_y};

  int checks = 0;
  int errors = 0;
  int ero_cnt = 0;
  int upd_cnt = 0;
  bit img [V_ACT][H_ACT];

  always #5 clk = ~clk;

  bin_erode_box #(.H_ACT(H_ACT), .V_ACT(V_ACT), .ROW(ROW)) dut (
    .clk(clk), .rst(rst), .i_pack(i_pack), .window(window), .o_pack(o_pack),
    .box_x_min(box_x_min), .box_x_max(box_x_max),
    .box_y_min(box_y_min), .box_y_max(box_y_max),
    .box_valid(box_valid), .box_update(box_update)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: a pixel is eroded when the last ROW samples of the current de run all
  // carried an all-white column; frame box = extents of eroded pixels between vsync rises.
  initial begin : model_and_compare
    int             run;
    logic [X_W-1:0] ax_min, ax_max, ex_min, ex_max;
    logic [Y_W-1:0] ay_min, ay_max, ey_min, ey_max;
    bit             aany, evalid, eupd, m1, m2, er;
    logic [PS-1:0]  eo;
    run = 0; aany = 0; evalid = 0; eupd = 0; m1 = 0; m2 = 0; er = 0;
    ax_min = X_W'(H_ACT - 1); ax_max = '0; ay_min = Y_W'(V_ACT - 1); ay_max = '0;
    ex_min = '0; ex_max = '0; ey_min = '0; ey_max = '0; eo = '0;
    forever begin
      @(posedge clk);
      #1;
      if (d_rst) begin
        run = 0; aany = 0; evalid = 0; eupd = 0; m1 = 0; m2 = 0; eo = '0;
        ax_min = X_W'(H_ACT - 1); ax_max = '0; ay_min = Y_W'(V_ACT - 1); ay_max = '0;
        ex_min = '0; ex_max = '0; ey_min = '0; ey_max = '0;
      end else begin
        eupd = m1 && !m2;
        if (eupd) begin
          ex_min = ax_min; ex_max = ax_max; ey_min = ay_min; ey_max = ay_max; evalid = aany;
          ax_min = X_W'(H_ACT - 1); ax_max = '0; ay_min = Y_W'(V_ACT - 1); ay_max = '0;
          aany = 0;
        end
        if (d_de && (&d_win)) run++;
        else run = 0;
        er = d_de && (run >= ROW);
        eo = {d_ck, d_hs, d_vs, d_de, {24{er}}, d_x, d_y};
        if (er) begin
          if (d_x < ax_min) ax_min = d_x;
          if (d_x > ax_max) ax_max = d_x;
          if (d_y < ay_min) ay_min = d_y;
          if (d_y > ay_max) ay_max = d_y;
          aany = 1;
        end
        m2 = m1;
        m1 = d_vs;
      end
      check("opack", o_pack, eo);
      check("box", {box_x_min, box_x_max, box_y_min, box_y_max, box_valid, box_update},
            {ex_min, ex_max, ey_min, ey_max, evalid, eupd});
      if (o_pack[PS-4] && (o_pack[X_W+Y_W +: 24] == 24'hFFFFFF)) ero_cnt++;
      if (box_update) upd_cnt++;
    end
  end

  task automatic step(input bit r, input bit hs, input bit vs, input bit de,
                      input int x, input int y, input logic [ROW-1:0] w);
    @(posedge clk);
    #2;
    d_rst = r; d_hs = hs; d_vs = vs; d_de = de;
    d_x = X_W'(x); d_y = Y_W'(y); d_win = w;
    d_rgb = 24'($urandom); d_ck = 1'($urandom);
  endtask

  function automatic logic [ROW-1:0] win_of(input int x, input int y);
    logic [ROW-1:0] w;
    w = '0;
    if (y >= ROW - 1)
      for (int j = 0; j < ROW; j++) w[j] = img[y - (ROW - 1) + j][x];
    return w;
  endfunction

  task automatic clear_img();
    for (int y = 0; y < V_ACT; y++)
      for (int x = 0; x < H_ACT; x++) img[y][x] = 1'b0;
  endtask

  task automatic fill_rect(input int x0, input int y0, input int w, input int h);
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++) img[y][x] = 1'b1;
  endtask

  // One frame: blanked lines of H_ACT pixels, then a vsync pulse; optional 1-cycle reset at (rx,ry).
  task automatic run_frame(input string name, input int gmin, input int gmax,
                           input int rx, input int ry);
    int g;
    ero_cnt = 0;
    upd_cnt = 0;
    for (int y = 0; y < V_ACT; y++) begin
      g = int'($urandom_range(gmin, gmax));
      for (int k = 0; k < g; k++)
        step(1'b0, k == 0, 1'b0, 1'b0, int'($urandom_range(0, H_ACT - 1)),
             int'($urandom_range(0, V_ACT - 1)), ROW'($urandom));
      for (int x = 0; x < H_ACT; x++)
        step((x == rx) && (y == ry), 1'b0, 1'b0, 1'b1, x, y, win_of(x, y));
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, '0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0);
    $display("frame %s: eroded=%0d updates=%0d box x %0d..%0d y %0d..%0d valid=%0b",
             name, ero_cnt, upd_cnt, box_x_min, box_x_max, box_y_min, box_y_max, box_valid);
  endtask

  task automatic check_frame(input string name, input int cnt, input int xmin, input int xmax,
                             input int ymin, input int ymax, input bit valid);
    check({name, "_eroded"}, ero_cnt, cnt);
    check({name, "_updates"}, upd_cnt, 1);
    check({name, "_box"}, {box_x_min, box_x_max, box_y_min, box_y_max, box_valid},
          {X_W'(xmin), X_W'(xmax), Y_W'(ymin), Y_W'(ymax), valid});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("rst_opack", o_pack, '0);
    check("rst_box", {box_x_min, box_x_max, box_y_min, box_y_max, box_valid, box_update}, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0);

    clear_img(); fill_rect(0, 0, H_ACT, V_ACT);
    run_frame("all_white", 2, 4, -1, -1);
    check_frame("all_white", 65, 3, 15, 3, 7, 1'b1);

    clear_img(); fill_rect(5, 2, 4, 4);
    run_frame("sq4_5_2", 1, 3, -1, -1);
    check_frame("sq4_5_2", 1, 8, 8, 5, 5, 1'b1);

    clear_img(); fill_rect(6, 3, 3, 3);
    run_frame("sq3", 1, 3, -1, -1);
    check_frame("sq3", 0, H_ACT - 1, 0, V_ACT - 1, 0, 1'b0);

    clear_img(); fill_rect(10, 3, 4, 4);
    run_frame("sq4_10_3", 1, 3, -1, -1);
    check_frame("sq4_10_3", 1, 13, 13, 6, 6, 1'b1);

    clear_img(); fill_rect(0, 0, 4, V_ACT); fill_rect(12, 0, 4, V_ACT);
    run_frame("edge_cols", 1, 1, -1, -1);
    check_frame("edge_cols", 10, 3, 15, 3, 7, 1'b1);

    clear_img(); fill_rect(7, 1, 4, 4); fill_rect(11, 4, 4, 4);
    run_frame("mid_reset", 1, 3, 13, 4);
    check_frame("mid_reset", 2, 14, 14, 7, 7, 1'b1);

    for (int f = 0; f < 6; f++) begin
      for (int y = 0; y < V_ACT; y++)
        for (int x = 0; x < H_ACT; x++) img[y][x] = ($urandom_range(0, 99) < 88);
      run_frame("random", 1, 4, -1, -1);
    end

    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0);
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
